// File: rtl/mcpu_soc_audio_pkg.sv
// Shared definitions for the audio serial interfaces (capture and playback).
//   audio_state_e     : deserializer/serializer slot-tracking states
//   AUDIO_WORD_BITS   : bits per channel word
//   AUDIO_FRAME_BITS  : bits per stereo frame {left, right}
//   LRCLK_LEFT/RIGHT  : channel-select encodings on the lrclk line
package mcpu_soc_audio_pkg;

  localparam int unsigned AUDIO_WORD_BITS  = 16;
  localparam int unsigned AUDIO_FRAME_BITS = 32;

  localparam logic LRCLK_LEFT  = 1'b0;
  localparam logic LRCLK_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_L,
    ST_SHIFT_L,
    ST_SHIFT_R
  } audio_state_e;

endpackage

// File: rtl/mcpu_soc_audio_fifo.sv
// Stereo frame buffer between the deserializer and the frame consumer.
// DEPTH >= 2 (power of two): circular FIFO; a push into a full FIFO is
// dropped unless a pop happens in the same cycle.
// DEPTH == 1: single output register; a push always lands, overwriting an
// unconsumed frame.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   push_i           : write push_data_i
//   push_data_i      : frame to store
//   pop_i            : discard head entry (ignored when empty)
//   pop_data_o       : head entry (registered storage)
//   full_o, empty_o  : occupancy status
module mcpu_soc_audio_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  if (DEPTH == 1) begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (push_i) begin
        data_q  <= push_data_i;
        valid_q <= 1'b1;
      end else if (pop_i) begin
        valid_q <= 1'b0;
      end
    end

    assign pop_data_o = data_q;
    assign full_o     = valid_q;
    assign empty_o    = ~valid_q;

  end else begin : g_ring
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_pop;
    logic             do_push;

    // A same-cycle pop frees the slot the push needs.
    always_comb begin
      do_pop  = pop_i & (count_q != '0);
      do_push = push_i & ((count_q != FULL_CNT) | do_pop);
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_data_i;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
  end

endmodule

// File: rtl/mcpu_soc_audio_in.sv
// Left-justified stereo serial audio capture (16 bits per channel).
// External bclk/lrclk/data are synchronized into the core clock domain,
// bclk rises are edge-detected, and a slot-tracking FSM assembles
// {left, right} frames that are queued towards the consumer.
// Build option MCPU_SOC_AUDIO_IN_FIFO_EN: when defined, frames are queued in
// a FIFO_DEPTH-entry FIFO; when undefined, a single overwrite-on-overflow
// output register is used and FIFO_DEPTH has no effect.
// Ports:
//   clkrst_core_clk/rst : core clock, synchronous active-high reset
//   ext_audio_bclk      : serial bit clock (async, <= core/8)
//   ext_audio_lrclk     : channel select, 0 = left, 1 = right
//   ext_audio_data      : serial data, MSB first
//   rx_enable           : capture enable; 0 idles the deserializer
//   frame_data/valid    : FIFO head {left, right} and its valid flag
//   frame_ready         : consumer accept
//   err_clear           : clears sticky error flags (wins over a set)
//   err_overflow        : sticky, frame lost to a full buffer
//   err_short           : sticky, channel slot shorter than 16 bits
module mcpu_soc_audio_in
  import mcpu_soc_audio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clkrst_core_clk,
  input  logic                        clkrst_core_rst,
  input  logic                        ext_audio_bclk,
  input  logic                        ext_audio_lrclk,
  input  logic                        ext_audio_data,
  input  logic                        rx_enable,
  output logic [AUDIO_FRAME_BITS-1:0] frame_data,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  input  logic                        err_clear,
  output logic                        err_overflow,
  output logic                        err_short
);

`ifdef MCPU_SOC_AUDIO_IN_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif
  localparam int unsigned BUF_DEPTH = FIFO_EN ? FIFO_DEPTH : 1;

  localparam int unsigned W = AUDIO_WORD_BITS;
  localparam logic [4:0] CNT_FULL = 5'(AUDIO_WORD_BITS);
  localparam logic [4:0] CNT_LAST = 5'(AUDIO_WORD_BITS - 1);

  // Synchronizers and bclk edge detection
  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrclk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   bclk_hist_q;
  logic                   bclk_s;
  logic                   lrclk_s;
  logic                   data_s;
  logic                   bclk_rise;

  // Deserializer state
  audio_state_e           state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [W-2:0]           shift_q, shift_d;
  logic [W-1:0]           left_q, left_d;
  logic                   left_valid_q, left_valid_d;
  logic                   seen_right_q, seen_right_d;
  logic                   push_q, push_d;
  logic [AUDIO_FRAME_BITS-1:0] push_data_q, push_data_d;
  logic [W-1:0]           new_word;
  logic                   short_set;

  // Buffer and error flags
  logic                   buf_full;
  logic                   buf_empty;
  logic                   pop;
  logic                   overflow_set;
  logic                   err_overflow_q, err_overflow_d;
  logic                   err_short_q, err_short_d;

  always_comb begin
    bclk_s    = bclk_sync_q[SYNC_STAGES-1];
    lrclk_s   = lrclk_sync_q[SYNC_STAGES-1];
    data_s    = data_sync_q[SYNC_STAGES-1];
    bclk_rise = bclk_s & ~bclk_hist_q;
    new_word  = {shift_q, data_s};
  end

  // Slot tracking. Each lrclk change is seen on the first bclk rise of the
  // new slot, which also carries that slot's MSB, so the counter restarts
  // at 1 rather than 0.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    left_d       = left_q;
    left_valid_d = left_valid_q;
    seen_right_d = seen_right_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    short_set    = 1'b0;

    if (!rx_enable) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      left_valid_d = 1'b0;
      seen_right_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_L;
        end

        ST_WAIT_L: begin
          if (bclk_rise) begin
            if (lrclk_s == LRCLK_RIGHT) begin
              seen_right_d = 1'b1;
            end else if (seen_right_q) begin
              state_d      = ST_SHIFT_L;
              cnt_d        = 5'd1;
              shift_d      = new_word[W-2:0];
              left_valid_d = 1'b0;
            end
          end
        end

        ST_SHIFT_L: begin
          if (bclk_rise) begin
            if (lrclk_s == LRCLK_RIGHT) begin
              if (cnt_q != CNT_FULL) begin
                short_set    = 1'b1;
                left_valid_d = 1'b0;
              end
              state_d = ST_SHIFT_R;
              cnt_d   = 5'd1;
              shift_d = new_word[W-2:0];
            end else if (cnt_q != CNT_FULL) begin
              cnt_d   = cnt_q + 5'd1;
              shift_d = new_word[W-2:0];
              if (cnt_q == CNT_LAST) begin
                left_d       = new_word;
                left_valid_d = 1'b1;
              end
            end
          end
        end

        ST_SHIFT_R: begin
          if (bclk_rise) begin
            if (lrclk_s == LRCLK_LEFT) begin
              if (cnt_q != CNT_FULL) begin
                short_set = 1'b1;
              end
              state_d      = ST_SHIFT_L;
              cnt_d        = 5'd1;
              shift_d      = new_word[W-2:0];
              left_valid_d = 1'b0;
            end else if (cnt_q != CNT_FULL) begin
              cnt_d   = cnt_q + 5'd1;
              shift_d = new_word[W-2:0];
              if (cnt_q == CNT_LAST) begin
                push_d      = left_valid_q;
                push_data_d = {left_q, new_word};
              end
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    pop            = frame_valid & frame_ready;
    overflow_set   = push_q & buf_full & ~pop;
    err_overflow_d = err_clear ? 1'b0 : (err_overflow_q | overflow_set);
    err_short_d    = err_clear ? 1'b0 : (err_short_q | short_set);
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      bclk_sync_q    <= '0;
      lrclk_sync_q   <= '0;
      data_sync_q    <= '0;
      bclk_hist_q    <= 1'b0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      left_q         <= '0;
      left_valid_q   <= 1'b0;
      seen_right_q   <= 1'b0;
      push_q         <= 1'b0;
      push_data_q    <= '0;
      err_overflow_q <= 1'b0;
      err_short_q    <= 1'b0;
    end else begin
      bclk_sync_q    <= {bclk_sync_q[SYNC_STAGES-2:0], ext_audio_bclk};
      lrclk_sync_q   <= {lrclk_sync_q[SYNC_STAGES-2:0], ext_audio_lrclk};
      data_sync_q    <= {data_sync_q[SYNC_STAGES-2:0], ext_audio_data};
      bclk_hist_q    <= bclk_s;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      left_q         <= left_d;
      left_valid_q   <= left_valid_d;
      seen_right_q   <= seen_right_d;
      push_q         <= push_d;
      push_data_q    <= push_data_d;
      err_overflow_q <= err_overflow_d;
      err_short_q    <= err_short_d;
    end
  end

  mcpu_soc_audio_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (AUDIO_FRAME_BITS)
  ) u_fifo (
    .clk_i       (clkrst_core_clk),
    .rst_i       (clkrst_core_rst),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (pop),
    .pop_data_o  (frame_data),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  assign frame_valid  = ~buf_empty;
  assign err_overflow = err_overflow_q;
  assign err_short    = err_short_q;

endmodule

// File: tb/tb_mcpu_soc_audio_in.sv
// Testbench for mcpu_soc_audio_in: serial stream generator with a
// slot-level reference model of framing, buffering and error flags.
module tb_mcpu_soc_audio_in;

  localparam int unsigned DEPTH = 4;
`ifdef MCPU_SOC_AUDIO_IN_FIFO_EN
  localparam int unsigned CAP       = DEPTH;
  localparam bit          FIFO_MODE = 1'b1;
`else
  localparam int unsigned CAP       = 1;
  localparam bit          FIFO_MODE = 1'b0;
`endif
  localparam int unsigned N_OVF = FIFO_MODE ? CAP + 2 : CAP + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        rx_en;
  logic        ready;
  logic        err_clr;
  logic [31:0] fdata;
  logic        fvalid;
  logic        ovf;
  logic        shrt;

  always #5 clk = ~clk;

  mcpu_soc_audio_in #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .ext_audio_bclk  (bclk),
    .ext_audio_lrclk (lrclk),
    .ext_audio_data  (sdata),
    .rx_enable       (rx_en),
    .frame_data      (fdata),
    .frame_valid     (fvalid),
    .frame_ready     (ready),
    .err_clear       (err_clr),
    .err_overflow    (ovf),
    .err_short       (shrt)
  );

  // Reference model state
  logic [31:0] exp_q[$];
  bit          m_seen_r;
  bit          m_locked;
  bit          m_left_full;
  logic [15:0] m_left;
  bit          exp_ovf;
  bit          exp_short;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned rx_count = 0;
  int unsigned base;
  logic [15:0] wl, wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_seen_r    = 1'b0;
    m_locked    = 1'b0;
    m_left_full = 1'b0;
    m_left      = '0;
    exp_ovf     = 1'b0;
    exp_short   = 1'b0;
  endtask

  task automatic model_push(input logic [31:0] f);
    if (ready || exp_q.size() < CAP) begin
      exp_q.push_back(f);
    end else begin
      if (!err_clr) exp_ovf = 1'b1;
      if (!FIFO_MODE) exp_q[exp_q.size()-1] = f;
    end
  endtask

  task automatic model_short();
    if (!err_clr) exp_short = 1'b1;
  endtask

  // Called on the last bclk rise of a slot of n bits.
  task automatic model_slot_end(input logic lr, input logic [15:0] w, input int unsigned n);
    if (lr == 1'b0) begin
      if (m_seen_r) m_locked = 1'b1;
      if (m_locked) begin
        m_left_full = (n == 16);
        m_left      = w;
        if (n < 16) model_short();
      end
    end else begin
      if (m_locked) begin
        if (n < 16) model_short();
        else if (m_left_full) model_push({m_left, w});
        m_left_full = 1'b0;
      end
      m_seen_r = 1'b1;
    end
  endtask

  // One slot: data/lrclk change on bclk fall, 16 core cycles per half period.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bclk  = 1'b0;
      lrclk = lr;
      sdata = w[15-i];
      repeat (16) @(posedge clk);
      #1;
      bclk = 1'b1;
      if (i == n - 1) model_slot_end(lr, w, n);
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 16);
    send_slot(1'b1, r, 16);
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bclk_idle();
    bclk = 1'b0;
    wait_cycles(16);
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr   = 1'b0;
    exp_ovf   = 1'b0;
    exp_short = 1'b0;
    wait_cycles(1);
  endtask

  task automatic drain(input string tag);
    int unsigned t;
    t = 0;
    ready = 1'b1;
    while ((exp_q.size() != 0 || fvalid) && t < 3000) begin
      wait_cycles(1);
      t++;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid"}, 32'(fvalid), 32'd0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "_short"}, 32'(shrt), 32'(exp_short));
  endtask

  // Consumer-side scoreboard
  always @(negedge clk) begin
    if (!rst && fvalid && ready) begin
      rx_count++;
      if (exp_q.size() == 0) check("spurious", 32'(fvalid), 32'd0);
      else check("frame", fdata, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    rx_en = 1'b1; ready = 1'b1; err_clr = 1'b0;
    model_reset();
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(1);
    check("rst_valid", 32'(fvalid), 32'd0);
    check("rst_data", fdata, 32'd0);
    check_flags("rst");

    // Stream joins mid right slot, then the fixed pattern
    send_slot(1'b1, 16'($urandom), 7);
    base = rx_count;
    repeat (6) send_frame(16'h7000, 16'h0001);
    bclk_idle();
    drain("pat");
    check("pat_count", rx_count - base, 32'd6);
    check_flags("pat");

    // Random frames, consumer always ready
    base = rx_count;
    for (int k = 0; k < 6; k++) begin
      wl = 16'($urandom);
      wr = 16'($urandom);
      send_frame(wl, wr);
    end
    bclk_idle();
    drain("rnd");
    check("rnd_count", rx_count - base, 32'd6);

    // Short left slot, then short right slot
    base = rx_count;
    send_slot(1'b0, 16'($urandom), 10);
    send_slot(1'b1, 16'($urandom), 16);
    check("short_l_flag", 32'(shrt), 32'(exp_short));
    send_frame(16'($urandom), 16'($urandom));
    send_slot(1'b0, 16'($urandom), 16);
    send_slot(1'b1, 16'($urandom), $urandom_range(1, 15));
    send_frame(16'($urandom), 16'($urandom));
    bclk_idle();
    drain("short");
    check("short_count", rx_count - base, 32'd2);
    check_flags("short");
    clear_flags();
    check_flags("short_clr");

    // Overflow with the consumer stalled, then drain in order
    ready = 1'b0;
    base  = rx_count;
    for (int unsigned k = 0; k < N_OVF; k++) send_frame(16'($urandom), 16'($urandom));
    bclk_idle();
    wait_cycles(10);
    check_flags("ovf");
    check("ovf_valid", 32'(fvalid), 32'd1);
    check("ovf_head", fdata, exp_q[0]);
    drain("ovf");
    check("ovf_count", rx_count - base, 32'(CAP));
    clear_flags();

    // err_clear held across an overflow event
    ready = 1'b0;
    base  = rx_count;
    for (int unsigned k = 0; k < CAP; k++) send_frame(16'($urandom), 16'($urandom));
    send_slot(1'b0, 16'($urandom), 16);
    err_clr = 1'b1;
    send_slot(1'b1, 16'($urandom), 16);
    wait_cycles(12);
    err_clr = 1'b0;
    bclk_idle();
    check_flags("clr");
    drain("clr");
    check("clr_count", rx_count - base, 32'(CAP));

    // Reset in the middle of a left slot
    base = rx_count;
    send_slot(1'b0, 16'($urandom), 8);
    bclk_idle();
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    model_reset();
    wait_cycles(1);
    check("rst2_valid", 32'(fvalid), 32'd0);
    send_slot(1'b0, 16'($urandom), 8);
    send_slot(1'b1, 16'($urandom), 16);
    wait_cycles(10);
    check("rst2_novalid", 32'(fvalid), 32'd0);
    send_frame(16'($urandom), 16'($urandom));
    send_frame(16'($urandom), 16'($urandom));
    bclk_idle();
    drain("rst2");
    check("rst2_count", rx_count - base, 32'd2);
    check_flags("end");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mcpu_soc_audio_in.md
MCPU_SOC_AUDIO_IN -- requirements
Module: mcpu_soc_audio_in

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: stereo frame FIFO entries, power of two, 2..16.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops on each external input, 2..3.
REQ-003 clkrst_core_clk  input  1  single core clock; all state on its rising edge.
REQ-004 clkrst_core_rst  input  1  reset, synchronous, active-high.
REQ-005 ext_audio_bclk  input  1  serial bit clock, asynchronous to core, at most core/8.
REQ-006 ext_audio_lrclk  input  1  channel select: 0 = left, 1 = right.
REQ-007 ext_audio_data  input  1  serial data, MSB first, stable at bclk rise.
REQ-008 rx_enable  input  1  1 = capture; 0 = deserializer idle, FIFO retained.
REQ-009 frame_data  output  32  {left[15:0], right[15:0]} at FIFO head.
REQ-010 frame_valid  output  1  FIFO head valid.
REQ-011 frame_ready  input  1  consumer accept; pop when frame_valid & frame_ready.
REQ-012 err_clear  input  1  clears sticky flags.
REQ-013 err_overflow  output  1  sticky: frame dropped because FIFO full.
REQ-014 err_short  output  1  sticky: channel slot ended with fewer than 16 bits.

Function
REQ-015 Each external input passes through SYNC_STAGES flops, then one history flop for edge detection.
REQ-016 Format is left-justified: the MSB occupies the first bclk period after an lrclk transition; 16 bits per channel.
REQ-017 A bclk rise is detected when synchronized bclk = 1 and history = 0; data and lrclk are sampled from their synchronized copies in that same cycle.
REQ-018 Deserializer states: IDLE, WAIT_L, SHIFT_L, SHIFT_R.
REQ-019 Transitions: IDLE -> WAIT_L when rx_enable; any state -> IDLE when rx_enable = 0.
REQ-020 WAIT_L -> SHIFT_L on the first bclk rise with sampled lrclk = 0 following one with lrclk = 1; that rise captures bit 15.
REQ-021 SHIFT_L -> SHIFT_R on the first rise with lrclk = 1, which captures right bit 15.
REQ-022 SHIFT_R -> SHIFT_L on a rise with lrclk = 0, which captures left bit 15.
REQ-023 A 5-bit bit counter, cleared on each lrclk change, saturates at 16; rises beyond bit 16 in a slot are ignored.
REQ-024 Left word latches when the counter reaches 16 in SHIFT_L.
REQ-025 Frame push occurs the cycle after the right counter reaches 16, provided a complete left word is held.
REQ-026 On an lrclk change with counter below 16, set err_short, discard that slot's word and the current frame, and continue in the new slot state.
REQ-027 Push into a full FIFO drops the new frame and sets err_overflow; a simultaneous pop frees space first, so push succeeds.
REQ-028 frame_data/frame_valid are registered; latency is no more than SYNC_STAGES+3 core cycles from the 16th right-channel bclk rise to frame_valid.
REQ-029 err_clear takes priority over a same-cycle flag set; flags clear next cycle.

Reset
REQ-030 On reset: state IDLE, counters 0, FIFO empty, frame_valid = 0, frame_data = 0, err_overflow = 0, err_short = 0, synchronizer and history flops 0.
REQ-031 Reset mid-frame discards partial words; no frame emerges from pre-reset bits.

Configuration
REQ-032 MCPU_SOC_AUDIO_IN_FIFO_EN defined: FIFO of FIFO_DEPTH entries as above.
REQ-033 MCPU_SOC_AUDIO_IN_FIFO_EN undefined: a single output register replaces the FIFO and FIFO_DEPTH is ignored; a push while valid & !ready overwrites the register and sets err_overflow.

Structure
REQ-034 A shared package mcpu_soc_audio_pkg holds the state enum, AUDIO_WORD_BITS = 16, AUDIO_FRAME_BITS = 32, and the lrclk channel encodings, for use by both audio directions.
REQ-035 FIFO is a sub-module mcpu_soc_audio_fifo with push/pop/full/empty; the deserializer stays in the top module.

Verification
REQ-036 Core clk, bclk = clk/32, left 0x7000 right 0x0001 repeated -> frames 0x70000001; frame_ready = 1 throughout; no flags set.
REQ-037 frame_ready = 0 for 6 frames, FIFO_DEPTH = 4 -> 4 frames held, err_overflow = 1; then drain yields the first 4 in order.
REQ-038 lrclk toggles after 10 bits in a left slot -> err_short = 1 and no frame for that period; the next full frame is received correctly.
REQ-039 Reset asserted after 8 left bits, released -> frame_valid stays 0 until a full new L/R pair; first frame equals the post-reset data.
REQ-040 Stream starting mid-right-slot -> first frame is the first complete left/right pair; err_clear together with an overflow event leaves err_overflow = 0.
REQ-041 Builds without MCPU_SOC_AUDIO_IN_FIFO_EN: 2 frames with frame_ready = 0 -> second frame visible and err_overflow = 1.
